// File: rtl/pattern_pkg.sv
// Shared pattern-generator definitions: mode encodings and the colour-bar table.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pattern_pkg;

  typedef enum logic [1:0] {
    HRAMP = 2'd0,
    VRAMP = 2'd1,
    BARS  = 2'd2,
    CHECK = 2'd3
  } mode_e;

  // Bar colours as {r,g,b} on/off flags, index 0 (left) to 7 (right):
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Pixel-coordinate in / registered-colour out bundle of the pattern generator.
// Latency: none (wiring only).
// Backpressure: none; the pixel stream advances every cycle.
interface pattern_gen_if #(
  parameter int CW   = 8,
  parameter int COLW = 11,
  parameter int ROWW = 10
);
  logic [ROWW-1:0] ROW;
  logic [COLW-1:0] COL;
  logic [1:0]      MODE;
  logic            SCROLL_EN;
  logic [CW-1:0]   R;
  logic [CW-1:0]   G;
  logic [CW-1:0]   B;
  logic            DE;

  // Timing source side: drives coordinates and controls, observes colour.
  modport master (output ROW, COL, MODE, SCROLL_EN, input R, G, B, DE);
  // Generator side.
  modport slave  (input ROW, COL, MODE, SCROLL_EN, output R, G, B, DE);
endinterface

// File: rtl/pattern_gen_rainbow_hue_map.sv
// Maps a hue sextant s (0..5) and fraction f to a fully saturated RGB colour.
// Latency: combinational.
// Backpressure: none.
module rainbow_hue_map #(
  parameter int CW = 8
) (
  input  logic [2:0]    s,
  input  logic [CW-1:0] f,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  // One channel ramps while the other two sit at MAX or 0; s 6/7 never occur.
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (s)
      3'd0: begin r = MAX;     g = f;       b = '0;      end
      3'd1: begin r = MAX - f; g = MAX;     b = '0;      end
      3'd2: begin r = '0;      g = MAX;     b = f;       end
      3'd3: begin r = '0;      g = MAX - f; b = MAX;     end
      3'd4: begin r = f;       g = '0;      b = MAX;     end
      3'd5: begin r = MAX;     g = '0;      b = MAX - f; end
      default: begin r = '0;   g = '0;      b = '0;      end
    endcase
  end
endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator: hue ramps, colour bars, checkerboard, per-frame scroll.
// Latency: 2 cycles from ROW/COL sample to R/G/B/DE.
// Backpressure: none; accepts one pixel per cycle, never stalls.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int CW          = 8,
  parameter int COLW        = 11,
  parameter int ROWW        = 10,
  parameter int HACT        = 800,
  parameter int VACT        = 600,
  parameter int STEP        = 2,
  parameter int SCROLL_STEP = 16,
  parameter int CHK_LOG     = 5
) (
  input  logic         CLK,
  input  logic         RST,
  pattern_gen_if.slave bus
);
  // Ramp period: six sextants of 2^CW each; offsets and p live in [0, PER).
  localparam int unsigned PER = 6 * (2 ** CW);
  localparam int OW = CW + 3;
  // Wide enough that pos*STEP + offset is exact for any 32-bit STEP.
  localparam int PW = (COLW > ROWW) ? COLW : ROWW;
  localparam int AW = PW + 34;

  localparam logic [AW-1:0] PER_W   = AW'(PER);
  localparam logic [AW-1:0] STEP_W  = AW'(STEP);
  localparam logic [AW-1:0] SCR_W   = AW'(SCROLL_STEP);
  localparam logic [AW-1:0] BARW_W  = AW'(HACT / 8);
  localparam logic [AW-1:0] HACT_W  = AW'(HACT);
  localparam logic [AW-1:0] VACT_W  = AW'(VACT);
  localparam logic [CW-1:0] MAX     = {CW{1'b1}};

  // Frame tracking state.
  logic          origin_q;
  mode_e         mode_q;
  logic [OW-1:0] offset;

  // Values in force for the pixel currently presented.
  logic          at_origin;
  logic          frame_start;
  mode_e         mode_eff;
  logic [OW-1:0] off_inc;
  logic [OW-1:0] off_eff;

  // Stage-1 combinational results.
  logic [AW-1:0] pos;
  logic [OW-1:0] p;
  logic [AW-1:0] bar_q;
  logic [2:0]    bar_idx;
  logic          chk;
  logic          active;

  // Stage-1 registers.
  mode_e         s1_mode;
  logic [2:0]    s1_s;
  logic [CW-1:0] s1_f;
  logic [2:0]    s1_bar;
  logic          s1_chk;
  logic          s1_act;

  // Stage-2 colour.
  logic [CW-1:0] hue_r, hue_g, hue_b;
  logic [CW-1:0] r_n, g_n, b_n;
  logic [CW-1:0] r_q, g_q, b_q;
  logic          de_q;
  logic [2:0]    bar_flags;

  // A frame starts on the first cycle at 0/0; that same pixel already sees the new mode and offset.
  always_comb begin
    at_origin   = (bus.ROW == '0) && (bus.COL == '0);
    frame_start = at_origin && !origin_q;
    off_inc     = OW'((AW'(offset) + SCR_W) % PER_W);
    mode_eff    = frame_start ? mode_e'(bus.MODE) : mode_q;
    off_eff     = (frame_start && bus.SCROLL_EN) ? off_inc : offset;
  end

  // Frame-start history, latched mode and scroll offset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      origin_q <= 1'b0;
      mode_q   <= HRAMP;
      offset   <= '0;
    end else begin
      origin_q <= at_origin;
      mode_q   <= mode_eff;
      offset   <= off_eff;
    end
  end

  // Ramp position, bar index, checker parity and active-area flag for the incoming pixel.
  always_comb begin
    pos     = (mode_eff == VRAMP) ? AW'(bus.ROW) : AW'(bus.COL);
    p       = OW'((pos * STEP_W + AW'(off_eff)) % PER_W);
    bar_q   = AW'(bus.COL) / BARW_W;
    bar_idx = (bar_q > AW'(7)) ? 3'd7 : 3'(bar_q);
    chk     = 1'((AW'(bus.COL) >> CHK_LOG) ^ (AW'(bus.ROW) >> CHK_LOG));
    active  = (AW'(bus.COL) < HACT_W) && (AW'(bus.ROW) < VACT_W);
  end

  // Stage 1: register the decomposed pixel (s = p / 2^CW, f = p mod 2^CW).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_mode <= HRAMP;
      s1_s    <= '0;
      s1_f    <= '0;
      s1_bar  <= '0;
      s1_chk  <= 1'b0;
      s1_act  <= 1'b0;
    end else begin
      s1_mode <= mode_eff;
      s1_s    <= p[OW-1:CW];
      s1_f    <= p[CW-1:0];
      s1_bar  <= bar_idx;
      s1_chk  <= chk;
      s1_act  <= active;
    end
  end

  rainbow_hue_map #(.CW(CW)) u_hue (
    .s (s1_s),
    .f (s1_f),
    .r (hue_r),
    .g (hue_g),
    .b (hue_b)
  );

  // Select the colour for the latched mode; blank outside the active area.
  always_comb begin
    r_n       = '0;
    g_n       = '0;
    b_n       = '0;
    bar_flags = bar_rgb(s1_bar);
    if (s1_act) begin
      case (s1_mode)
        HRAMP, VRAMP: begin
          r_n = hue_r;
          g_n = hue_g;
          b_n = hue_b;
        end
        BARS: begin
          r_n = {CW{bar_flags[2]}};
          g_n = {CW{bar_flags[1]}};
          b_n = {CW{bar_flags[0]}};
        end
        CHECK: begin
          r_n = s1_chk ? MAX : '0;
          g_n = s1_chk ? MAX : '0;
          b_n = s1_chk ? MAX : '0;
        end
        default: begin
          r_n = '0;
          g_n = '0;
          b_n = '0;
        end
      endcase
    end
  end

  // Stage 2: registered colour and aligned data-enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      de_q <= 1'b0;
    end else begin
      r_q  <= r_n;
      g_q  <= g_n;
      b_q  <= b_n;
      de_q <= s1_act;
    end
  end

  assign bus.R  = r_q;
  assign bus.G  = g_q;
  assign bus.B  = b_q;
  assign bus.DE = de_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: directed spec points plus randomized pixels vs a reference model.
// Latency: expects each pixel's colour exactly 2 clocks after it is sampled.
// Backpressure: none; one pixel is driven every cycle.
module tb_pattern_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pattern_gen_if #(.CW(8), .COLW(11), .ROWW(10)) bus();

  pattern_gen dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [24:0] exp;   // {de, r, g, b}
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state.
  int   m_off  = 0;
  int   m_mode = 0;
  bit   m_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hue wheel from the sextant table, on a ramp position in [0,1536).
  function automatic logic [23:0] hue(input int p);
    int s;
    int f;
    s = p / 256;
    f = p % 256;
    case (s)
      0: return {8'd255, 8'(f), 8'd0};
      1: return {8'(255 - f), 8'd255, 8'd0};
      2: return {8'd0, 8'd255, 8'(f)};
      3: return {8'd0, 8'(255 - f), 8'd255};
      4: return {8'(f), 8'd0, 8'd255};
      default: return {8'd255, 8'd0, 8'(255 - f)};
    endcase
  endfunction

  function automatic logic [24:0] model_px(input int row, input int col);
    int idx;
    if (!(col < 800 && row < 600)) return 25'd0;
    case (m_mode)
      0: return {1'b1, hue((col * 2 + m_off) % 1536)};
      1: return {1'b1, hue((row * 2 + m_off) % 1536)};
      2: begin
        idx = col / 100;
        if (idx > 7) idx = 7;
        case (idx)
          0: return {1'b1, 24'hFFFFFF};
          1: return {1'b1, 24'hFFFF00};
          2: return {1'b1, 24'h00FFFF};
          3: return {1'b1, 24'h00FF00};
          4: return {1'b1, 24'hFF00FF};
          5: return {1'b1, 24'hFF0000};
          6: return {1'b1, 24'h0000FF};
          default: return {1'b1, 24'h000000};
        endcase
      end
      default: return (((col >> 5) ^ (row >> 5)) & 1) != 0 ? {1'b1, 24'hFFFFFF}
                                                            : {1'b1, 24'h000000};
    endcase
  endfunction

  // Drive one pixel on the falling edge and queue its expected colour.
  task automatic drive(input int row, input int col, input int md, input bit scr,
                       input bit use_lit, input logic [24:0] lit, input string name);
    exp_t e;
    bit   org;
    @(negedge clk);
    bus.ROW       = 10'(row);
    bus.COL       = 11'(col);
    bus.MODE      = 2'(md);
    bus.SCROLL_EN = scr;
    org = (row == 0) && (col == 0);
    if (org && !m_prev) begin
      m_mode = md;
      if (scr) m_off = (m_off + 16) % 1536;
    end
    m_prev = org;
    e.due  = cyc + 2;
    e.exp  = use_lit ? lit : model_px(row, col);
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic px(input int row, input int col, input int md, input bit scr);
    drive(row, col, md, scr, 1'b0, 25'd0, "random");
  endtask

  task automatic dx(input int row, input int col, input int md, input bit scr,
                    input logic [24:0] lit, input string name);
    drive(row, col, md, scr, 1'b1, lit, name);
  endtask

  task automatic check_now(input logic [24:0] exp, input string name);
    logic [24:0] got;
    got = {bus.DE, bus.R, bus.G, bus.B};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got rgb=(%0d,%0d,%0d) de=%0d, expected rgb=(%0d,%0d,%0d) de=%0d",
               name, got[23:16], got[15:8], got[7:0], got[24],
               exp[23:16], exp[15:8], exp[7:0], exp[24]);
    end
  endtask

  // Monitor: pop every expectation whose output cycle has arrived and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check_now(e.exp, e.name);
      end
    end
  end

  initial begin
    int row;
    int col;
    int guard;
    bus.ROW       = '0;
    bus.COL       = '0;
    bus.MODE      = '0;
    bus.SCROLL_EN = 1'b0;

    // Outputs held at zero while reset is asserted.
    repeat (2) @(negedge clk);
    check_now(25'd0, "reset_state");
    rst_n = 1'b1;

    // Horizontal ramp, offset 0.
    dx(0, 0, 0, 0,    {1'b1, 24'hFF0000}, "ramp_col0");
    dx(1, 128, 0, 0,  {1'b1, 24'hFFFF00}, "ramp_col128");
    dx(10, 200, 0, 0, {1'b1, 24'h6FFF00}, "ramp_col200");

    // Colour bars.
    dx(0, 0, 2, 0,    {1'b1, 24'hFFFFFF}, "bars_origin");
    dx(3, 450, 2, 0,  {1'b1, 24'hFF00FF}, "bar_col450");
    dx(3, 799, 2, 0,  {1'b1, 24'h000000}, "bar_col799");
    dx(3, 850, 2, 0,  {1'b0, 24'h000000}, "bar_col850_blank");
    dx(700, 10, 2, 0, {1'b0, 24'h000000}, "row700_blank");

    // Checkerboard.
    dx(0, 0, 3, 0,    {1'b1, 24'h000000}, "chk_origin");
    dx(0, 32, 3, 0,   {1'b1, 24'hFFFFFF}, "chk_32_0");
    dx(32, 32, 3, 0,  {1'b1, 24'h000000}, "chk_32_32");

    // MODE change mid-frame waits for the next frame start.
    dx(0, 0, 0, 0,    {1'b1, 24'hFF0000}, "fs_ramp");
    dx(5, 300, 2, 0,  {1'b1, 24'h00FF58}, "midframe_still_ramp");
    dx(6, 300, 2, 0,  {1'b1, 24'h00FF58}, "midframe_still_ramp2");
    dx(0, 0, 2, 0,    {1'b1, 24'hFFFFFF}, "fs_bars");
    dx(5, 300, 2, 0,  {1'b1, 24'h00FF00}, "bars_after_fs");

    // Scroll: 0/0 held for five cycles advances the offset once.
    for (int i = 0; i < 5; i++) dx(0, 0, 0, 1, {1'b1, 24'hFF1000}, "scroll_hold");
    dx(2, 2, 0, 1,    {1'b1, 24'hFF1400}, "scroll_once");
    dx(0, 0, 0, 1,    {1'b1, 24'hFF2000}, "scroll_second");
    dx(3, 0, 0, 0,    {1'b1, 24'hFF2000}, "scroll_col0");

    // Randomized pixels against the reference model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        row = 0;
        col = 0;
      end else begin
        row = int'($urandom_range(0, 650));
        col = int'($urandom_range(0, 900));
      end
      px(row, col, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Mid-frame reset while white checker pixels are on the outputs.
    px(0, 0, 3, 0);
    for (int i = 0; i < 3; i++) px(0, 32, 3, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_now(25'd0, "async_reset_immediate");
    sbq.delete();
    m_off  = 0;
    m_mode = 0;
    m_prev = 1'b0;
    repeat (3) @(negedge clk);
    check_now(25'd0, "reset_hold");
    rst_n = 1'b1;

    // After release: mode_q=0 and offset=0 even though MODE input is 2.
    dx(4, 200, 2, 0,  {1'b1, 24'h6FFF00}, "post_reset_mode_offset");
    dx(0, 0, 1, 0,    {1'b1, 24'hFF0000}, "vramp_origin");
    dx(200, 5, 1, 0,  {1'b1, 24'h6FFF00}, "vramp_row200");
    for (int i = 0; i < 3; i++) px(700, 900, 0, 0);

    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d expectations still pending, required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL expose parameter CW, default 8, meaning colour channel width in bits.
REQ-002 The block SHALL expose parameter COLW, default 11, meaning COL input width.
REQ-003 The block SHALL expose parameter ROWW, default 10, meaning ROW input width.
REQ-004 The block SHALL expose parameter HACT, default 800, meaning active columns.
REQ-005 The block SHALL expose parameter VACT, default 600, meaning active rows.
REQ-006 The block SHALL expose parameter STEP, default 2, meaning ramp increment per pixel.
REQ-007 The block SHALL expose parameter SCROLL_STEP, default 16, meaning ramp offset increment per frame.
REQ-008 The block SHALL expose parameter CHK_LOG, default 5, meaning checker cell size is 2^CHK_LOG pixels.
REQ-009 The block SHALL have port CLK, input, 1 bit: single clock.
REQ-010 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-011 The block SHALL have port ROW, input, ROWW bits, unsigned: current pixel row.
REQ-012 The block SHALL have port COL, input, COLW bits, unsigned: current pixel column.
REQ-013 The block SHALL have port MODE, input, 2 bits: pattern select.
REQ-014 The block SHALL have port SCROLL_EN, input, 1 bit: enables per-frame ramp animation.
REQ-015 The block SHALL have ports R, G and B, each output, CW bits: registered colour.
REQ-016 The block SHALL have port DE, output, 1 bit: registered active-area flag aligned with R, G and B.

Function
REQ-017 Notation: MAX = 2^CW-1; PER = 6*2^CW; active = (COL<HACT && ROW<VACT).
REQ-018 Frame start SHALL be a cycle with ROW==0 && COL==0 when the previous cycle did not satisfy that condition; holding 0/0 for several cycles counts once.
REQ-019 On frame start, mode_q SHALL load MODE; a MODE change at any other time SHALL have no effect until the next frame start.
REQ-020 On frame start with SCROLL_EN=1, offset SHALL become (offset+SCROLL_STEP) mod PER; with SCROLL_EN=0, offset SHALL hold.
REQ-021 The pixel that causes a frame start SHALL already use the new mode_q and offset.
REQ-022 Ramp position SHALL be p = (pos*STEP + offset) mod PER, computed exactly with no truncation; pos = COL in mode 0 and ROW in mode 1.
REQ-023 Hue mapping SHALL use s = p / 2^CW and f = p mod 2^CW.
REQ-024 Hue mapping for s0 through s2 SHALL be: s0 (MAX,f,0); s1 (MAX-f,MAX,0); s2 (0,MAX,f).
REQ-025 Hue mapping for s3 through s5 SHALL be: s3 (0,MAX-f,MAX); s4 (f,0,MAX); s5 (MAX,0,MAX-f).
REQ-026 Mode 2 SHALL draw 8 vertical bars with index = COL/(HACT/8), clamped to 7.
REQ-027 Mode 2 bar colours, index 0 to 7, SHALL be white, yellow, cyan, green, magenta, red, blue, black, with channels at MAX or 0.
REQ-028 Mode 3 SHALL output all-MAX when ((COL>>CHK_LOG)^(ROW>>CHK_LOG)) bit 0 is 1, and all-0 otherwise.
REQ-029 Outside the active area, R, G and B SHALL be 0 and DE SHALL be 0, in every mode.
REQ-030 Latency SHALL be exactly 2 cycles from ROW/COL sample to R/G/B/DE (stage 1: p, s, f, bar/checker and active flag registered; stage 2: colour registered).
REQ-031 Throughput SHALL be one pixel per cycle, with no stalls.

Reset
REQ-032 While RST=0, R, G, B, DE, all pipeline registers, offset, mode_q and the frame-start history SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-034 After release, the first valid output SHALL appear 2 cycles after the first sampled pixel.

Structure
REQ-035 Shared package pattern_pkg SHALL hold the MODE encodings (HRAMP=0, VRAMP=1, BARS=2, CHECK=3) and the 8-entry bar colour table.
REQ-036 One combinational sub-module, rainbow_hue_map, SHALL map (s, f) to (R, G, B), parameterised by CW.

Verification
REQ-037 The bench SHALL cover mode 0, offset 0, with defaults: COL=0 and COL=128 SHALL give (255,0,0) and (255,255,0); COL=200, ROW=10 SHALL give (111,255,0) with DE=1, 2 cycles later.
REQ-038 The bench SHALL cover mode 2: COL=450 SHALL give (255,0,255); COL=799 SHALL give (0,0,0) with DE=1; COL=850 SHALL give (0,0,0) with DE=0.
REQ-039 The bench SHALL cover mode 3: (COL,ROW)=(32,0) SHALL give (255,255,255); (32,32) SHALL give (0,0,0).
REQ-040 The bench SHALL cover scrolling: SCROLL_EN=1 over two frame starts, then mode 0 COL=0 SHALL give (255,32,0); with 0/0 held 5 cycles, offset SHALL advance once only.
REQ-041 The bench SHALL cover a mid-frame mode change: MODE 0->2 at COL=300 SHALL leave outputs at the ramp until the next frame start, then bars.
REQ-042 The bench SHALL cover reset mid-frame: RST low SHALL force outputs 0 immediately; after release, offset SHALL be 0 and mode_q SHALL be 0.
